des_result_serializer: RTL and testbench
========================================

// Module: des_result_serializer
// PURPOSE
//   Receive end of the DES core output: captures each 64-bit cipher_text word presented with
//   des_top's valid_out, buffers words in a small FIFO, and streams them out MSB-first as
//   OUT_W-bit beats over a valid/ready handshake toward the narrow chip-level IO port.
//   Counterpart of the wide parallel load path that feeds plain_text/cipher_key into des_top.
// PARAMETERS
//   DEPTH   2   word FIFO depth (64-bit entries), >=1, power of two
//   OUT_W   8   output beat width in bits; must divide 64 (BEATS = 64/OUT_W)
// PORTS
//   clk            in   1       system clock, all logic on rising edge
//   rst            in   1       synchronous reset, active-high
//   cipher_text    in   64      result word from des_top
//   cipher_valid   in   1       des_top valid_out; one-cycle pulse per result word
//   flush          in   1       synchronous: discard FIFO contents and word in flight
//   byte_data      out  OUT_W   current output beat, MSB slice of word first
//   byte_valid     out  1       byte_data valid
//   byte_ready     in   1       sink accepts beat when byte_valid & byte_ready at clk edge
//   byte_last      out  1       high with the final beat (BEATS-1) of a word
//   fifo_count     out  $clog2(DEPTH)+1  words held in FIFO (excludes word in shifter)
//   busy           out  1       shifter holds a word or fifo_count != 0
//   overflow       out  1       sticky: a word was dropped because FIFO was full
// BEHAVIOUR
//   Reset (rst=1 at edge): byte_valid=0, byte_last=0, byte_data=0, fifo_count=0, busy=0,
//     overflow=0, FSM=IDLE, beat counter=0. Reset mid-word abandons the word, no further beats.
//   Push: at edge with cipher_valid=1, word is written to FIFO if not full, or if full and a
//     pop occurs on the same edge (simultaneous push+pop on full is accepted).
//     Full with no pop: word dropped, overflow<=1; only rst clears overflow.
//   FSM states: IDLE, SHIFT.
//     IDLE: byte_valid=0. If fifo_count!=0 at edge: pop head into shift register, beat=0,
//       -> SHIFT. A word pushed into an empty FIFO at edge N is popped at N+1; its first beat
//       is valid after edge N+1 (2-cycle latency from cipher_valid to byte_valid).
//     SHIFT: byte_valid=1, byte_data = word[63-beat*OUT_W -: OUT_W], byte_last=(beat==BEATS-1).
//       Handshake (byte_valid & byte_ready): beat advances. While byte_ready=0, byte_data,
//       byte_last and beat are held stable.
//       Final-beat handshake: if FIFO non-empty, pop next word on the same edge and stay in
//       SHIFT with beat=0 (no bubble between words); else -> IDLE.
//   flush=1 at edge: FIFO emptied, shifter discarded, FSM->IDLE, byte_valid=0 next cycle;
//     overflow unchanged; cipher_valid on the same edge is discarded.
//     rst has priority over flush.
//   fifo_count = pushes - pops, saturating only by push rejection; never exceeds DEPTH.
//   Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH; full/empty decided from fifo_count.
//   byte_valid never depends combinationally on byte_ready (registered outputs).
// TESTING
//   1 Reset: rst=1 two cycles with cipher_valid toggling -> all outputs 0, fifo_count=0, overflow=0.
//   2 Single word 64'h85E813540F0AB405, byte_ready=1 -> beats 85,E8,13,54,0F,0A,B4,05;
//     byte_valid rises 2 cycles after capture; byte_last only on 05; then IDLE, busy=0.
//   3 Backpressure: same word, byte_ready=0 for 3 cycles during beat 3 -> byte_data holds 54,
//     no beat skipped or duplicated.
//   4 Overflow (DEPTH=2): 4 back-to-back cipher_valid pulses, byte_ready=0 -> word1 in shifter,
//     fifo_count=2, word4 dropped, overflow=1; release ready -> words 1,2,3 out in order.
//   5 Back-to-back: two words queued, byte_ready=1 -> 16 consecutive valid beats, no gap,
//     byte_last on beats 8 and 16.
//   6 Flush mid-word at beat 4 with one word queued -> byte_valid=0 next cycle, fifo_count=0;
//     subsequent new word streams correctly from its MSB beat.

Source files
------------

// File: rtl/des_result_serializer.sv
// Serializes 64-bit DES result words into OUT_W-bit beats, MSB slice first, over valid/ready.
// A small word FIFO absorbs results arriving while the shifter is still draining a word.
module des_result_serializer #(
    parameter int DEPTH = 2,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              cipher_text,
    input  logic                     cipher_valid,
    input  logic                     flush,
    output logic [OUT_W-1:0]         byte_data,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     byte_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     overflow
);

    localparam int BEATS  = 64 / OUT_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [63:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               overflow_reg;
    logic [63:0]        word_reg;
    logic [BEAT_W-1:0]  beat_reg;
    logic [BEAT_W-1:0]  beat_next;

    logic               fifo_empty;
    logic               fifo_full;
    logic               handshake;
    logic               final_beat;
    logic               pop;
    logic               push;
    logic               drop;

    logic [OUT_W-1:0]   beat_slices [BEATS];

    // Slice k of the held word is beat k; the word itself never shifts.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
            assign beat_slices[gi] = word_reg[63 - gi*OUT_W -: OUT_W];
        end
    endgenerate

    always_comb begin
        fifo_empty = (count_reg == '0);
        fifo_full  = (count_reg == CNT_W'(DEPTH));
        handshake  = (state_reg == SHIFT) && byte_ready;
        final_beat = (beat_reg == BEAT_W'(BEATS - 1));
        // A pop refills the shifter either from idle or on the last beat, so words chain with no bubble.
        pop        = !flush && !fifo_empty && ((state_reg == IDLE) || (handshake && final_beat));
        push       = cipher_valid && !flush && (!fifo_full || pop);
        drop       = cipher_valid && !flush && fifo_full && !pop;
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_comb begin
        beat_next = beat_reg;
        if (pop || (handshake && final_beat)) begin
            beat_next = '0;
        end else if (handshake) begin
            beat_next = beat_reg + BEAT_W'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (handshake && final_beat && fifo_empty) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM: outputs, driven only from registers so nothing loops back from byte_ready
    always_comb begin
        byte_valid = (state_reg == SHIFT);
        byte_data  = byte_valid ? beat_slices[beat_reg] : '0;
        byte_last  = byte_valid && final_beat;
        busy       = byte_valid || (count_reg != '0);
        fifo_count = count_reg;
        overflow   = overflow_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            beat_reg     <= '0;
            overflow_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            beat_reg     <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            beat_reg     <= beat_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage and its registered read; byte_data is gated by state so word_reg needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= cipher_text;
        end
        if (pop) begin
            word_reg <= mem[rd_ptr_reg];
        end
    end

endmodule

// File: tb/tb_des_result_serializer.sv
// Self-checking bench for des_result_serializer: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_des_result_serializer;

    localparam int DEPTH = 2;
    localparam int OUT_W = 8;

    logic        clk;
    logic        rst;
    logic [63:0] cipher_text;
    logic        cipher_valid;
    logic        flush;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic [1:0]  fifo_count;
    logic        busy;
    logic        overflow;

    des_result_serializer #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cipher_text  (cipher_text),
        .cipher_valid (cipher_valid),
        .flush        (flush),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .byte_last    (byte_last),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .overflow     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: queue of words waiting, one word being emitted, beat index.
    logic [63:0] m_fifo[$];
    logic        m_active;
    logic [63:0] m_word;
    int          m_beat;
    logic        m_overflow;

    logic [7:0]  got_q[$];
    logic        got_last[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] w, input int i);
        logic [63:0] t;
        t = (w >> (56 - 8*i)) & 64'hFF;
        return t[7:0];
    endfunction

    task automatic model_step(input logic cv, input logic [63:0] w, input logic fl,
                              input logic rdy, input logic r);
        logic        hs;
        logic        done;
        logic        do_pop;
        logic        accept;
        logic [63:0] popped;
        if (r) begin
            m_fifo.delete();
            m_active = 0; m_beat = 0; m_word = '0; m_overflow = 0;
        end else if (fl) begin
            m_fifo.delete();
            m_active = 0; m_beat = 0;
        end else begin
            hs     = m_active && rdy;
            done   = hs && (m_beat == 7);
            do_pop = (m_fifo.size() > 0) && (!m_active || done);
            accept = 0;
            if (cv) begin
                if (m_fifo.size() < DEPTH || do_pop) accept = 1;
                else m_overflow = 1;
            end
            if (do_pop) begin
                popped   = m_fifo.pop_front();
                m_word   = popped;
                m_beat   = 0;
                m_active = 1;
            end else if (done) begin
                m_active = 0;
                m_beat   = 0;
            end else if (hs) begin
                m_beat++;
            end
            if (accept) m_fifo.push_back(w);
        end
    endtask

    task automatic compare_outputs();
        logic [7:0] exp_data;
        exp_data = m_active ? byte_of(m_word, m_beat) : 8'h00;
        check("byte_valid", {63'd0, byte_valid}, {63'd0, m_active});
        check("byte_data",  {56'd0, byte_data},  {56'd0, exp_data});
        check("byte_last",  {63'd0, byte_last},  {63'd0, (m_active && m_beat == 7)});
        check("fifo_count", {62'd0, fifo_count}, 64'(m_fifo.size()));
        check("busy",       {63'd0, busy},       {63'd0, (m_active || m_fifo.size() != 0)});
        check("overflow",   {63'd0, overflow},   {63'd0, m_overflow});
    endtask

    // One clock: drive inputs, log an accepted beat, advance model, sample after the edge.
    task automatic cyc(input logic cv, input logic [63:0] w, input logic fl,
                       input logic rdy, input logic r);
        rst = r; cipher_valid = cv; cipher_text = w; flush = fl; byte_ready = rdy;
        if (!r && !fl && byte_valid && rdy) begin
            got_q.push_back(byte_data);
            got_last.push_back(byte_last);
        end
        model_step(cv, w, fl, rdy, r);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic check_word(input string tag, input logic [63:0] w, input int off);
        if (got_q.size() < off + 8) begin
            check({tag, "_beats"}, 64'(got_q.size()), 64'(off + 8));
        end else begin
            for (int i = 0; i < 8; i++) begin
                check(tag, {56'd0, got_q[off+i]}, {56'd0, byte_of(w, i)});
                check({tag, "_last"}, {63'd0, got_last[off+i]}, {63'd0, (i == 7)});
            end
        end
    endtask

    task automatic reset_dut();
        cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        got_q.delete();
        got_last.delete();
    endtask

    logic [63:0] kw;
    logic [63:0] w1, w2, w3, w4;
    int          found;
    int          run_len;

    initial begin
        rst = 1; cipher_valid = 0; cipher_text = '0; flush = 0; byte_ready = 0;
        m_active = 0; m_beat = 0; m_word = '0; m_overflow = 0;
        kw = 64'h85E813540F0AB405;

        // 1: reset held two cycles while cipher_valid toggles
        cyc(1'b1, kw, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, kw, 1'b0, 1'b1, 1'b1);
        check("t1_count", {62'd0, fifo_count}, 64'd0);
        check("t1_overflow", {63'd0, overflow}, 64'd0);
        check("t1_data", {56'd0, byte_data}, 64'd0);

        // 2: single known word, sink always ready
        reset_dut();
        cyc(1'b1, kw, 1'b0, 1'b1, 1'b0);
        check("t2_lat_edge1", {63'd0, byte_valid}, 64'd0);
        idle(1, 1'b1);
        check("t2_lat_edge2", {63'd0, byte_valid}, 64'd1);
        check("t2_first_beat", {56'd0, byte_data}, 64'h85);
        idle(10, 1'b1);
        check_word("t2_word", kw, 0);
        check("t2_busy_end", {63'd0, busy}, 64'd0);

        // 3: backpressure while beat 3 (0x54) is presented
        reset_dut();
        cyc(1'b1, kw, 1'b0, 1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (byte_valid && byte_data == 8'h54) found = 1;
            else idle(1, 1'b1);
        end
        check("t3_reach_beat3", 64'(found), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b0);
            check("t3_hold", {56'd0, byte_data}, 64'h54);
        end
        idle(10, 1'b1);
        check_word("t3_word", kw, 0);
        check("t3_beats", 64'(got_q.size()), 64'd8);

        // 4: overflow with four back-to-back pulses and the sink stalled
        reset_dut();
        w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom};
        w3 = {$urandom, $urandom}; w4 = {$urandom, $urandom};
        cyc(1'b1, w1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, w2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, w3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, w4, 1'b0, 1'b0, 1'b0);
        check("t4_count", {62'd0, fifo_count}, 64'd2);
        check("t4_overflow", {63'd0, overflow}, 64'd1);
        check("t4_head", {56'd0, byte_data}, {56'd0, byte_of(w1, 0)});
        idle(30, 1'b1);
        check_word("t4_w1", w1, 0);
        check_word("t4_w2", w2, 8);
        check_word("t4_w3", w3, 16);
        check("t4_total", 64'(got_q.size()), 64'd24);

        // 5: two queued words stream without a gap
        reset_dut();
        w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom};
        cyc(1'b1, w1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, w2, 1'b0, 1'b1, 1'b0);
        run_len = 0;
        for (int i = 0; i < 20; i++) begin
            if (byte_valid) run_len++;
            else if (run_len > 0) break;
            idle(1, 1'b1);
        end
        check("t5_run_len", 64'(run_len), 64'd16);
        check_word("t5_w1", w1, 0);
        check_word("t5_w2", w2, 8);

        // 6: flush while beat 4 is presented and one word waits
        reset_dut();
        w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom}; w3 = {$urandom, $urandom};
        cyc(1'b1, w1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, w2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20 && got_q.size() < 4; i++) idle(1, 1'b1);
        check("t6_at_beat4", 64'(got_q.size()), 64'd4);
        check("t6_pre_count", {62'd0, fifo_count}, 64'd1);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        check("t6_valid", {63'd0, byte_valid}, 64'd0);
        check("t6_count", {62'd0, fifo_count}, 64'd0);
        got_q.delete();
        got_last.delete();
        cyc(1'b1, w3, 1'b0, 1'b1, 1'b0);
        idle(12, 1'b1);
        check_word("t6_w3", w3, 0);
        check("t6_total", 64'(got_q.size()), 64'd8);

        // 7: random traffic, model comparison every cycle
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 30), {$urandom, $urandom},
                ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
                ($urandom_range(0, 999) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
